// File: rtl/ddr3_dma_write_packer_pkg.sv
// Shared definitions for the DDR3 DMA write packer: FSM state encoding,
// default widths, and the lane/ceil-divide helpers.
package ddr3_dma_write_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_STREAM    = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam int DEF_DMA_ADDR_WIDTH = 27;
  localparam int DEF_IN_WIDTH       = 64;
  localparam int DEF_OUT_WIDTH      = 512;
  localparam int DEF_LEN_WIDTH      = 30;

  // Number of narrow lanes in one packed word (RATIO).
  function automatic int lane_ratio(input int out_w, input int in_w);
    return out_w / in_w;
  endfunction

  // LANE_BITS = log2(RATIO); RATIO is a power of two.
  function automatic int lane_bits(input int ratio);
    return $clog2(ratio);
  endfunction

  // ceil(len / 2**lbits) using the round-up-then-shift form.
  function automatic logic [63:0] ceil_div_pow2(input logic [63:0] len, input int lbits);
    logic [63:0] round_up;
    round_up = (64'd1 << lbits) - 64'd1;
    return (len + round_up) >> lbits;
  endfunction

endpackage

// File: rtl/ddr3_word_packer.sv
// Packs narrow input words into one wide DDR word and handles the
// in_valid/in_ready and din_rdy/din_en handshakes around that register.
module ddr3_word_packer
  import ddr3_dma_write_packer_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_active,
  input  logic                 i_in_done,
  input  logic                 i_final,
  input  logic                 i_in_valid,
  input  logic [IN_WIDTH-1:0]  i_in_data,
  input  logic                 i_din_rdy,
  output logic                 o_in_ready,
  output logic                 o_accept,
  output logic                 o_din_en,
  output logic [OUT_WIDTH-1:0] o_din,
  output logic                 o_din_eop
);

  localparam int NLANES = lane_ratio(OUT_WIDTH, IN_WIDTH);
  localparam int LBITS  = lane_bits(NLANES);
  localparam logic [LBITS-1:0] LAST_LANE = LBITS'(NLANES - 1);

  logic [OUT_WIDTH-1:0] r_pack;
  logic [OUT_WIDTH-1:0] w_pack_next;
  logic [LBITS-1:0]     r_lane;
  logic                 r_full;
  logic                 r_last;
  logic                 w_din_en;
  logic                 w_accept;

  // A full register can still take a new word in the same cycle it drains.
  assign w_din_en   = i_active & r_full & i_din_rdy;
  assign o_in_ready = i_active & ~i_in_done & (~r_full | i_din_rdy);
  assign w_accept   = o_in_ready & i_in_valid;
  assign o_accept   = w_accept;
  assign o_din_en   = w_din_en;
  assign o_din      = r_pack;
  assign o_din_eop  = w_din_en & r_last;

  // Next pack value: start from zero when the current word drains this cycle.
  always_comb begin
    w_pack_next = w_din_en ? '0 : r_pack;
    w_pack_next[int'(r_lane) * IN_WIDTH +: IN_WIDTH] = i_in_data;
  end

  // Pack register, lane pointer and full/last flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pack <= '0;
      r_lane <= '0;
      r_full <= 1'b0;
      r_last <= 1'b0;
    end else if (w_accept) begin
      r_pack <= w_pack_next;
      if (r_lane == LAST_LANE || i_final) begin
        r_full <= 1'b1;
        r_lane <= '0;
        r_last <= i_final;
      end else begin
        r_full <= 1'b0;
        r_lane <= r_lane + LBITS'(1);
        r_last <= 1'b0;
      end
    end else if (w_din_en) begin
      r_pack <= '0;
      r_full <= 1'b0;
      r_last <= 1'b0;
    end
  end

endmodule

// File: rtl/ddr3_dma_write_packer.sv
// Command FSM for the DDR3 DMA write feeder: accepts a command, issues the
// write request, streams packed words through ddr3_word_packer and reports
// completion once the engine signals write_done.
module ddr3_dma_write_packer
  import ddr3_dma_write_packer_pkg::*;
#(
  parameter int DMA_ADDR_WIDTH = DEF_DMA_ADDR_WIDTH,
  parameter int IN_WIDTH       = DEF_IN_WIDTH,
  parameter int OUT_WIDTH      = DEF_OUT_WIDTH,
  parameter int LEN_WIDTH      = DEF_LEN_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [DMA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]      cmd_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_WIDTH-1:0]       in_data,
  input  logic                      in_last,
  output logic                      write_req,
  output logic [DMA_ADDR_WIDTH-1:0] write_start_addr,
  output logic [DMA_ADDR_WIDTH-1:0] write_length,
  input  logic                      write_done,
  input  logic                      din_rdy,
  output logic                      din_en,
  output logic [OUT_WIDTH-1:0]      din,
  output logic                      din_eop,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int NLANES = lane_ratio(OUT_WIDTH, IN_WIDTH);
  localparam int LBITS  = lane_bits(NLANES);

  state_t                    r_state;
  logic                      r_cmd_ready;
  logic                      r_write_req;
  logic [DMA_ADDR_WIDTH-1:0] r_addr;
  logic [DMA_ADDR_WIDTH-1:0] r_len;
  logic                      r_done;
  logic                      r_err;
  logic [LEN_WIDTH-1:0]      r_rem;
  logic                      r_in_done;

  logic                      w_cmd_acc;
  logic [DMA_ADDR_WIDTH-1:0] w_words;
  logic                      w_stream;
  logic                      w_rem_one;
  logic                      w_final;
  logic                      w_accept;
  logic                      w_din_eop;

  assign w_cmd_acc = cmd_valid & r_cmd_ready;
  assign w_words   = DMA_ADDR_WIDTH'(ceil_div_pow2(64'(cmd_len), LBITS));
  assign w_stream  = (r_state == ST_STREAM);
  assign w_rem_one = (r_rem == LEN_WIDTH'(1));
  assign w_final   = w_rem_one | in_last;

  assign cmd_ready        = r_cmd_ready;
  assign write_req        = r_write_req;
  assign write_start_addr = r_addr;
  assign write_length     = r_len;
  assign done             = r_done;
  assign err              = r_err;
  assign busy             = (r_state != ST_IDLE);
  assign din_eop          = w_din_eop;

  ddr3_word_packer #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_active   (w_stream),
    .i_in_done  (r_in_done),
    .i_final    (w_final),
    .i_in_valid (in_valid),
    .i_in_data  (in_data),
    .i_din_rdy  (din_rdy),
    .o_in_ready (in_ready),
    .o_accept   (w_accept),
    .o_din_en   (din_en),
    .o_din      (din),
    .o_din_eop  (w_din_eop)
  );

  // Command FSM with registered handshake/pulse outputs and input counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b1;
      r_write_req <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rem       <= '0;
      r_in_done   <= 1'b0;
    end else begin
      r_write_req <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_acc) begin
            // The engine cannot run a burst shorter than two words.
            if (w_words < DMA_ADDR_WIDTH'(2)) begin
              r_err <= 1'b1;
            end else begin
              r_addr      <= cmd_addr;
              r_len       <= w_words;
              r_rem       <= cmd_len;
              r_in_done   <= 1'b0;
              r_write_req <= 1'b1;
              r_cmd_ready <= 1'b0;
              r_state     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          r_state <= ST_STREAM;
        end
        ST_STREAM: begin
          if (w_accept) begin
            r_rem <= r_rem - LEN_WIDTH'(1);
            if (w_final) r_in_done <= 1'b1;
          end
          if (w_din_eop) r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (write_done) begin
            r_done      <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_dma_write_packer.sv
// Bench for ddr3_dma_write_packer: a transfer-level model predicts the request
// fields and every packed beat; a monitor compares them on each negedge.
module tb_ddr3_dma_write_packer;

  localparam int AW = 27;
  localparam int IW = 64;
  localparam int OW = 512;
  localparam int LW = 30;
  localparam int R  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic          write_req;
  logic [AW-1:0] write_start_addr;
  logic [AW-1:0] write_length;
  logic          write_done;
  logic          din_rdy;
  logic          din_en;
  logic [OW-1:0] din;
  logic          din_eop;
  logic          busy;
  logic          done;
  logic          err;

  ddr3_dma_write_packer dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_addr         (cmd_addr),
    .cmd_len          (cmd_len),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .in_last          (in_last),
    .write_req        (write_req),
    .write_start_addr (write_start_addr),
    .write_length     (write_length),
    .write_done       (write_done),
    .din_rdy          (din_rdy),
    .din_en           (din_en),
    .din              (din),
    .din_eop          (din_eop),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [OW-1:0] exp_din_q[$];
  bit            exp_eop_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] exp_len_q[$];
  logic [OW-1:0] cap_q[$];
  logic [AW-1:0] cap_len;
  int  exp_req_total = 0;
  int  exp_err       = 0;
  int  exp_done      = 0;
  int  n_req  = 0;
  int  n_err  = 0;
  int  n_done = 0;
  int  n_acc  = 0;
  bit  eop_seen = 0;
  int  rdy_mode = 0;

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_msg(input string nm);
    checks++;
    failures++;
    $display("FAIL %s", nm);
  endtask

  // Transfer-level model: request fields and the expected packed beats.
  task automatic model_cmd(input logic [AW-1:0] addr, input int len,
                           input logic [IW-1:0] base, input int last_idx);
    int words, n_eff, nb, idx;
    logic [OW-1:0] beat;
    words = (len + R - 1) / R;
    if (words < 2) begin
      exp_err++;
    end else begin
      exp_req_total++;
      exp_addr_q.push_back(addr);
      exp_len_q.push_back(AW'(words));
      n_eff = (last_idx >= 0 && last_idx < len) ? last_idx + 1 : len;
      nb = (n_eff + R - 1) / R;
      for (int b = 0; b < nb; b++) begin
        beat = '0;
        for (int j = 0; j < R; j++) begin
          idx = b * R + j;
          if (idx < n_eff) beat[j*IW +: IW] = base + IW'(idx);
        end
        exp_din_q.push_back(beat);
        exp_eop_q.push_back(b == nb - 1);
      end
    end
  endtask

  // Engine-side din_rdy pattern.
  initial begin
    din_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       din_rdy = 1'b1;
        1:       din_rdy = 1'($urandom % 2);
        default: din_rdy = 1'b0;
      endcase
    end
  end

  // Monitor: every beat and request checked against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) n_acc++;
      if (din_en) begin
        cap_q.push_back(din);
        if (exp_din_q.size() == 0) begin
          fail_msg("unexpected_din_en");
        end else begin
          chk("din", OW'(din), exp_din_q.pop_front());
          chk("din_eop", OW'(din_eop), OW'(exp_eop_q.pop_front()));
        end
        if (din_eop) eop_seen = 1;
      end
      if (write_req) begin
        n_req++;
        cap_len = write_length;
        if (exp_addr_q.size() == 0) begin
          fail_msg("unexpected_write_req");
        end else begin
          chk("write_start_addr", OW'(write_start_addr), OW'(exp_addr_q.pop_front()));
          chk("write_length", OW'(write_length), OW'(exp_len_q.pop_front()));
        end
      end
      if (done) n_done++;
      if (err)  n_err++;
    end
  end

  task automatic send_cmd(input logic [AW-1:0] addr, input int len);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = LW'(len);
    @(negedge clk);
    chk("cmd_ready_idle", OW'(cmd_ready), OW'(1));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input int n, input logic [IW-1:0] base, input int last_idx);
    int cnt;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + IW'(i);
      in_last  = (i == last_idx);
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!in_ready && cnt < 300);
      if (!in_ready) fail_msg("in_ready_timeout");
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic finish_cmd();
    int cnt;
    cnt = 0;
    while (!eop_seen && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    if (!eop_seen) fail_msg("eop_timeout");
    @(posedge clk);
    #1;
    chk("busy_wait_done", OW'(busy), OW'(1));
    write_done = 1'b1;
    @(posedge clk);
    #1;
    write_done = 1'b0;
    @(negedge clk);
    chk("done_pulse", OW'(done), OW'(1));
    chk("busy_after_done", OW'(busy), OW'(0));
    chk("cmd_ready_after_done", OW'(cmd_ready), OW'(1));
    exp_done++;
    @(negedge clk);
    chk("done_one_cycle", OW'(done), OW'(0));
  endtask

  task automatic run_full(input logic [AW-1:0] addr, input int len,
                          input logic [IW-1:0] base);
    model_cmd(addr, len, base, -1);
    eop_seen = 0;
    send_cmd(addr, len);
    feed(len, base, -1);
    finish_cmd();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, OW'(cmd_ready), OW'(1));
    chk({tag, "_busy"}, OW'(busy), OW'(0));
    chk({tag, "_in_ready"}, OW'(in_ready), OW'(0));
    chk({tag, "_write_req"}, OW'(write_req), OW'(0));
    chk({tag, "_write_len"}, OW'(write_length), OW'(0));
    chk({tag, "_write_addr"}, OW'(write_start_addr), OW'(0));
    chk({tag, "_din_en"}, OW'(din_en), OW'(0));
    chk({tag, "_din"}, din, OW'(0));
    chk({tag, "_din_eop"}, OW'(din_eop), OW'(0));
    chk({tag, "_done"}, OW'(done), OW'(0));
    chk({tag, "_err"}, OW'(err), OW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; write_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: len 16 -> two full beats
    run_full(AW'(32'h100), 16, 64'd0);
    chk("t1_cap_len", OW'(cap_len), OW'(2));
    chk("t1_beat0_lane0", OW'(cap_q[0][63:0]), OW'(0));
    chk("t1_beat0_lane7", OW'(cap_q[0][511:448]), OW'(7));
    chk("t1_beat1_lane7", OW'(cap_q[1][511:448]), OW'(15));

    // 2: len 20 -> three beats, last one half filled
    run_full(AW'(32'h180), 20, 64'd0);
    chk("t2_cap_len", OW'(cap_len), OW'(3));
    chk("t2_beat2_lane3", OW'(cap_q[4][255:192]), OW'(19));
    chk("t2_beat2_upper_zero", OW'(cap_q[4][511:256]), OW'(0));

    // 3: len 24 with in_last on the tenth input
    model_cmd(AW'(32'h200), 24, 64'd0, 9);
    eop_seen = 0;
    send_cmd(AW'(32'h200), 24);
    feed(10, 64'd0, 9);
    in_valid = 1'b1;
    in_data  = 64'hDEAD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_in_ready_after_last", OW'(in_ready), OW'(0));
    end
    in_valid = 1'b0;
    finish_cmd();
    chk("t3_cap_len", OW'(cap_len), OW'(3));
    chk("t3_beat1_lane1", OW'(cap_q[6][127:64]), OW'(9));
    chk("t3_beat1_upper_zero", OW'(cap_q[6][511:128]), OW'(0));

    // 4: back-pressure, then random din_rdy over 64 inputs
    rdy_mode = 2;
    model_cmd(AW'(32'h300), 64, 64'h1000, -1);
    eop_seen = 0;
    send_cmd(AW'(32'h300), 64);
    n_acc = 0;
    fork
      feed(64, 64'h1000, -1);
      begin
        repeat (20) @(negedge clk);
        chk("t4_accepts_when_stalled", OW'(n_acc), OW'(8));
        chk("t4_in_ready_stalled", OW'(in_ready), OW'(0));
        rdy_mode = 1;
      end
    join
    finish_cmd();
    rdy_mode = 0;

    // 5: short command rejected; stray write_done in IDLE ignored
    @(posedge clk);
    #1;
    write_done = 1'b1;
    @(posedge clk);
    #1;
    write_done = 1'b0;
    model_cmd(AW'(32'h400), 5, 64'd0, -1);
    send_cmd(AW'(32'h400), 5);
    @(negedge clk);
    chk("t5_err_pulse", OW'(err), OW'(1));
    chk("t5_busy", OW'(busy), OW'(0));
    chk("t5_cmd_ready", OW'(cmd_ready), OW'(1));
    @(negedge clk);
    chk("t5_err_one_cycle", OW'(err), OW'(0));
    run_full(AW'(32'h480), 16, 64'h2000);

    // 6: reset mid-stream, then a clean command
    model_cmd(AW'(32'h500), 16, 64'h5000, -1);
    eop_seen = 0;
    send_cmd(AW'(32'h500), 16);
    feed(3, 64'h5000, -1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_din_q.delete();
    exp_eop_q.delete();
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_full(AW'(32'h600), 16, 64'h3000);

    repeat (3) @(negedge clk);
    chk("total_write_req", OW'(n_req), OW'(exp_req_total));
    chk("total_err", OW'(n_err), OW'(exp_err));
    chk("total_done", OW'(n_done), OW'(exp_done));
    chk("beats_outstanding", OW'(exp_din_q.size()), OW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr3_dma_write_packer.md
Name: ddr3_dma_write_packer

Overview:
Upstream feeder for the DDR3 DMA write engine. Accepts one write command (DDR word address plus length in narrow input words) and a narrow result stream from the compute pipeline. Packs RATIO input words into each wide DDR word, issues the single-cycle write request, and drives the din/din_en/din_eop stream under the engine's din_rdy flow control. Reports completion when the engine's write_done returns.

Parameters:
DMA_ADDR_WIDTH, 27, width of DDR address and length fields
IN_WIDTH, 64, narrow input word width
OUT_WIDTH, 512, packed DDR word width; RATIO = OUT_WIDTH/IN_WIDTH, which must be an integer power of two
LEN_WIDTH, 30, width of cmd_len in input words

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_addr  in  DMA_ADDR_WIDTH  DDR start address, passed through unchanged
cmd_len  in  LEN_WIDTH  transfer length in input words
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid & in_ready
in_data  in  IN_WIDTH  input word
in_last  in  1  early end of stream; marks the final input word
write_req  out  1  one-cycle request pulse to the DMA engine
write_start_addr  out  DMA_ADDR_WIDTH  latched cmd_addr
write_length  out  DMA_ADDR_WIDTH  number of packed words
write_done  in  1  engine completion pulse
din_rdy  in  1  engine can take a word
din_en  out  1  packed word transfer
din  out  OUT_WIDTH  packed word
din_eop  out  1  final packed word, qualified by din_en
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset values: cmd_ready=1, all other outputs 0; pack register and counters cleared.
- Reset mid-transfer: return to IDLE, discard the partially packed word, no done pulse.
- State IDLE: cmd_ready=1.
  - On cmd accept, latch addr; compute words = ceil(cmd_len/RATIO) = (cmd_len+RATIO-1)>>log2(RATIO), truncated to DMA_ADDR_WIDTH.
  - The engine requires at least 2 words. If words<2: pulse err next cycle and stay in IDLE; no write_req is issued.
  - Otherwise go to REQ.
- State REQ: write_req=1 for exactly one cycle; write_start_addr and write_length are stable from this cycle until the next command. Next state: STREAM.
- State STREAM:
  - in_ready = ~in_done & (~full | din_rdy).
  - An accepted input is written to lane lane_idx, at bits [lane_idx*IN_WIDTH +: IN_WIDTH]; the first word goes in the LSBs. lane_idx then increments.
  - The remaining-input counter (rem) decrements on each accept.
  - Word completion: when lane RATIO-1 is written, or rem==1, or in_last, set full the next cycle.
    - Unwritten lanes of a short word are zero.
    - After rem==1 or in_last, set in_done and record that this word is the last.
- Output side:
  - din_en = full & din_rdy; din is the pack register; din_eop = din_en & last_word.
  - Simultaneous din_en and input accept: the register is treated as cleared, the new word goes to lane 0, and full drops. Sustained throughput is one input word per cycle.
  - After the eop word transfers, go to WAIT_DONE.
- Early in_last: the command's length is still what was issued as write_length. The engine terminates on din_eop, so the short transfer is legal.
- State WAIT_DONE: on write_done, pulse done for one cycle (registered) and return to IDLE. A write_done seen in any other state is ignored.
- No input is consumed outside STREAM. in_data is never buffered beyond the single pack register.

Decomposition:
- Shared package: state encoding (IDLE, REQ, STREAM, WAIT_DONE), RATIO, LANE_BITS = log2(RATIO), and the ceil-divide function.
- One natural sub-module: ddr3_word_packer. It holds the pack register, lane_idx, full, last_word, and the in/out handshake.
- The command FSM and counters stay in the top level.

Test Plan:
1. RATIO=8; cmd addr=0x100, len=16; inputs 0..15 -> one write_req with start=0x100 and length=2. Two din_en beats: beat 0 has lanes = 0..7, beat 1 has lanes = 8..15 with din_eop. Return write_done -> done pulse, busy falls.
2. cmd len=20 -> write_length=3. Third beat has lanes 0-3 = 16..19, lanes 4-7 = 0, and din_eop.
3. cmd len=24 with in_last on input 10 -> write_length=3. Two beats; the second beat has lanes 0-1 = 8,9 and zeros elsewhere, with din_eop. in_ready stays low after in_last.
4. din_rdy held low; in_valid continuous -> 8 inputs accepted, then in_ready=0 until din_rdy rises. Same-cycle din_en plus accept loses no data, verified over 64 inputs with random din_rdy.
5. cmd len=5 -> err pulse, no write_req, stays in IDLE; the next valid command proceeds normally.
6. rst asserted mid-STREAM after 3 inputs -> all outputs at reset values next cycle. A following len=16 command produces clean beats with no stale lanes.
